// File: rtl/instr_trace_monitor.sv
// Instruction trace monitor: captures changes of instr_in during a timed run into a show-ahead FIFO.
// Optional per-entry timestamp storage is enabled by defining TRACE_TIMESTAMP_EN.
module instr_trace_monitor #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int TS_W       = 24,
    parameter int MAX_CYCLES = 5888000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] instr_in,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_instr,
    output logic [TS_W-1:0]   rd_ts,
    output logic              running,
    output logic              done,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [TS_W-1:0]   cnt_q, cnt_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_q, drop_d;

    logic [DATA_W-1:0] instr_mem [DEPTH];

    logic empty, full, pop, capture, push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = rd_valid && rd_ready && !start;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        last_d     = last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        capture    = 1'b0;
        push       = 1'b0;
        if (start) begin
            // A (re)start wipes the trace; the first RUN cycle follows.
            state_d    = RUN;
            cnt_d      = '0;
            first_d    = 1'b1;
            overflow_d = 1'b0;
            drop_d     = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (state_q == RUN) begin
                capture = first_q || (instr_in != last_q);
                cnt_d   = cnt_q + 1'b1;
                if (stop || (cnt_q == TS_W'(MAX_CYCLES - 1))) begin
                    state_d = DONE;
                end
            end
            if (capture) begin
                first_d = 1'b0;
                last_d  = instr_in;
                // A pop in the same cycle frees a slot, so a full FIFO still accepts.
                if (!full || pop) begin
                    push = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q[AW-1:0]] <= instr_in;
        end
    end

    assign rd_valid = !empty;
    assign rd_instr = rd_valid ? instr_mem[rd_ptr_q[AW-1:0]] : '0;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr_q[AW-1:0]] <= cnt_q;
        end
    end

    assign rd_ts = rd_valid ? ts_mem[rd_ptr_q[AW-1:0]] : '0;
`else
    assign rd_ts = '0;
`endif

    assign running  = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;
endmodule
